fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage; owns the program counter.
- Issues in-order requests to the instruction memory over a valid/ready request channel with decoupled responses.
- Buffers returned instructions, each tagged with its PC, and presents them to decode as {pc, pc_plus4, instruction} with a valid/ready handshake.
- Handles branch/jump redirects from execute, including squashing in-flight fetches.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BUF_DEPTH, 2, fetch-buffer entries; also the maximum in-flight requests plus buffered entries (power of 2, ≥2).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request this cycle.
- imem_addr_o  out  DATA_WIDTH  fetch address (equals the current PC).
- imem_rsp_valid_i  in  1  response valid; responses return in order, ≥1 cycle after acceptance.
- imem_rsp_data_i  in  DATA_WIDTH  returned instruction.
- redirect_i  in  1  taken branch/jump from execute.
- redirect_pc_i  in  DATA_WIDTH  redirect target.
- id_ready_i  in  1  decode accepts the head entry (low = stall).
- if_valid_o  out  1  head entry valid toward decode.
- if_pc_o  out  DATA_WIDTH  PC of the head entry.
- if_pc_plus4_o  out  DATA_WIDTH  if_pc_o + 4.
- if_instruction_o  out  DATA_WIDTH  instruction of the head entry.

Behaviour:
- Reset (rst=1 at an edge):
  - pc ← RESET_PC; buffer, pending-PC queue, outstanding count and drop count ← 0.
  - While rst is high: imem_req_valid_o=0, if_valid_o=0, data outputs 0.
- Credit rule:
  - imem_req_valid_o = !rst && !redirect_i && (outstanding + occupancy < BUF_DEPTH).
  - The outstanding count includes responses still to be dropped.
  - The buffer can therefore never overflow.
- Request accept (valid && ready):
  - Push the current pc into the pending-PC queue.
  - pc ← pc+4, modulo 2^DATA_WIDTH (0xFFFFFFFC wraps to 0).
  - Outstanding +1.
- Response (imem_rsp_valid_i):
  - Outstanding −1 and pop the pending-PC queue.
  - If drop count > 0: discard the response and decrement drop count.
  - Otherwise: write {popped pc, data} into the buffer tail.
  - A response with outstanding = 0 is illegal; ignore it and flag it with an assertion.
- Output:
  - Head entry drives the pc, pc_plus4 and instruction outputs.
  - if_valid_o = !empty && !redirect_i.
  - Pop when if_valid_o && id_ready_i.
  - A response arriving while the buffer is empty appears at the output the next cycle (1-cycle response-to-decode latency).
  - Simultaneous push and pop are allowed at any occupancy.
- Redirect (redirect_i=1):
  - Flush the buffer.
  - pc ← {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}.
  - drop count ← outstanding after this cycle's response. Any response in the redirect cycle is discarded regardless of drop count.
  - No request is issued in the redirect cycle.
  - The first request to the target is issued the next cycle, if credit allows.
  - Redirect has priority over every other event in the same cycle.
- Stall (id_ready_i=0):
  - Head entry and its outputs hold stable; if_valid_o stays high.
  - Fetching continues until the credit rule blocks.
- Reset mid-operation: discards all in-flight and buffered state. The memory must not return responses to requests issued before reset.

Test Plan:
- Reset then free-run (imem ready=1, 1-cycle responses, id_ready=1) → first req addr 0x0 in cycle after rst drops; decode sees pc 0x0,0x4,0x8… one per cycle, pc_plus4 = pc+4.
- id_ready_i=0 for 5 cycles with responses flowing → at most 2 requests outstanding+buffered, head pc held constant, no instruction lost or duplicated after release.
- Redirect to 0x100 with 2 requests in flight → both late responses discarded; next decode-visible pc is 0x100, then 0x104.
- Redirect to 0x103 coincident with a response → response dropped; next fetch address 0x100.
- PC at 0xFFFFFFFC → next request address 0x0; if_pc_plus4_o = 0x0 for that entry.
- Assert rst mid-stream with buffer full → next cycle if_valid_o=0, imem_req_valid_o=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response channel, execute redirect
// and the decode-facing handshake. master = fetch stage, slave = its environment.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid_o;
    logic                  imem_req_ready_i;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_rsp_valid_i;
    logic [DATA_WIDTH-1:0] imem_rsp_data_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic                  id_ready_i;
    logic                  if_valid_o;
    logic [DATA_WIDTH-1:0] if_pc_o;
    logic [DATA_WIDTH-1:0] if_pc_plus4_o;
    logic [DATA_WIDTH-1:0] if_instruction_o;

    modport master (
        output imem_req_valid_o, imem_addr_o,
        output if_valid_o, if_pc_o, if_pc_plus4_o, if_instruction_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  redirect_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o,
        input  if_valid_o, if_pc_o, if_pc_plus4_o, if_instruction_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output redirect_i, redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order credit-limited fetches,
// tags responses with their PC in a small buffer and squashes fetches on redirect.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    localparam int            PW      = $clog2(BUF_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] buf_pc_q    [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc_d    [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_instr_d [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] pend_pc_q   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] pend_pc_d   [BUF_DEPTH];
    logic [PW-1:0]         buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic [PW-1:0]         pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [CW-1:0]         occ_q, occ_d, out_q, out_d, drop_q, drop_d;
    logic                  req_valid, req_fire, rsp_ok, rsp_keep, if_valid, pop;

    always_comb begin
        // Outstanding includes responses still to be dropped, so the buffer can never overflow.
        req_valid = !rst && !bus.redirect_i && ((out_q + occ_q) < DEPTH_C);
        req_fire  = req_valid && bus.imem_req_ready_i;
        rsp_ok    = bus.imem_rsp_valid_i && (out_q != '0);
        rsp_keep  = rsp_ok && (drop_q == '0) && !bus.redirect_i;
        if_valid  = !rst && (occ_q != '0) && !bus.redirect_i;
        pop       = if_valid && bus.id_ready_i;
    end

    always_comb begin
        pc_d        = pc_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        pend_pc_d   = pend_pc_q;
        buf_rd_d    = buf_rd_q;
        buf_wr_d    = buf_wr_q;
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        drop_d      = drop_q;

        if (req_fire) begin
            pend_pc_d[pend_wr_q] = pc_q;
            pend_wr_d            = pend_wr_q + 1'b1;
            pc_d                 = pc_q + DATA_WIDTH'(4);
        end
        if (rsp_ok) begin
            pend_rd_d = pend_rd_q + 1'b1;
        end
        if (rsp_ok && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        if (rsp_keep) begin
            buf_pc_d[buf_wr_q]    = pend_pc_q[pend_rd_q];
            buf_instr_d[buf_wr_q] = bus.imem_rsp_data_i;
            buf_wr_d              = buf_wr_q + 1'b1;
        end
        if (pop) begin
            buf_rd_d = buf_rd_q + 1'b1;
        end

        occ_d = occ_q + CW'(rsp_keep) - CW'(pop);
        out_d = out_q + CW'(req_fire) - CW'(rsp_ok);

        // Redirect wins: flush the buffer and drop every response still owed after this cycle.
        if (bus.redirect_i) begin
            pc_d     = {bus.redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            buf_rd_d = '0;
            buf_wr_d = '0;
            occ_d    = '0;
            drop_d   = out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            buf_rd_q  <= '0;
            buf_wr_q  <= '0;
            pend_rd_q <= '0;
            pend_wr_q <= '0;
            occ_q     <= '0;
            out_q     <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            buf_rd_q  <= buf_rd_d;
            buf_wr_q  <= buf_wr_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
            occ_q     <= occ_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_pc_q    <= buf_pc_d;
        buf_instr_q <= buf_instr_d;
        pend_pc_q   <= pend_pc_d;
    end

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_addr_o      = rst ? '0 : pc_q;
    assign bus.if_valid_o       = if_valid;
    assign bus.if_pc_o          = rst ? '0 : buf_pc_q[buf_rd_q];
    assign bus.if_pc_plus4_o    = rst ? '0 : buf_pc_q[buf_rd_q] + DATA_WIDTH'(4);
    assign bus.if_instruction_o = rst ? '0 : buf_instr_q[buf_rd_q];

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        bus.imem_rsp_valid_i |-> (out_q != '0));
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with random latency, directed scenarios
// plus a random phase, and a scoreboard of the expected program-order decode stream.
module tb_fetch_stage;
    localparam int          DW        = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if #(.DATA_WIDTH(DW)) bus ();

    fetch_stage #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;
    logic [31:0] exp_fetch;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          pops   = 0;
    int          dmin   = 1;
    int          dmax   = 1;

    // Instruction word stored at each address of the modelled memory.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive inputs on the falling edge, answer the memory queue,
    // then record the request handshake that the next rising edge will complete.
    task automatic step(input bit r, input bit redir, input logic [31:0] tgt,
                        input bit idr, input bit rdy);
        @(negedge clk);
        cyc++;
        rst                  = r;
        bus.redirect_i       = redir;
        bus.redirect_pc_i    = tgt;
        bus.id_ready_i       = idr;
        bus.imem_req_ready_i = rdy;
        if (r) mq.delete();
        if (!r && mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = $urandom;
        end
        if (r) begin
            exp_q.delete();
            exp_tail  = RESET_PC - 32'd4;
            exp_fetch = RESET_PC;
        end else if (redir) begin
            exp_q.delete();
            exp_tail  = (tgt & ~32'd3) - 32'd4;
            exp_fetch = tgt & ~32'd3;
        end
        while (exp_q.size() < 16) begin
            exp_tail = exp_tail + 32'd4;
            exp_q.push_back(exp_tail);
        end
        #1;
        if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
            mq.push_back('{addr: bus.imem_addr_o, due: cyc + int'($urandom_range(dmin, dmax))});
            check("credit_limit", 32'(mq.size() <= BUF_DEPTH), 32'd1);
        end
    endtask

    // Monitor: compares every decode handshake and fetch address with the model.
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc, hold_in, e;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check("rst_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
                check("rst_if_valid", 32'(bus.if_valid_o), 32'd0);
                check("rst_if_pc", bus.if_pc_o, 32'd0);
                check("rst_if_instr", bus.if_instruction_o, 32'd0);
                hold_v = 1'b0;
            end else if (bus.redirect_i) begin
                check("redir_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
                check("redir_if_valid", 32'(bus.if_valid_o), 32'd0);
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("stall_valid", 32'(bus.if_valid_o), 32'd1);
                    check("stall_pc", bus.if_pc_o, hold_pc);
                    check("stall_instr", bus.if_instruction_o, hold_in);
                end
                if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
                    check("fetch_addr", bus.imem_addr_o, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (bus.if_valid_o && bus.id_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL decode_extra: got pc %h expected no entry", bus.if_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("decode_pc", bus.if_pc_o, e);
                        check("decode_pc_plus4", bus.if_pc_plus4_o, e + 32'd4);
                        check("decode_instr", bus.if_instruction_o, instr_of(e));
                        pops++;
                    end
                end
                hold_v  = bus.if_valid_o && !bus.id_ready_i;
                hold_pc = bus.if_pc_o;
                hold_in = bus.if_instruction_o;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  p0;
        bit  found;
        rst                  = 1'b1;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.id_ready_i       = 1'b0;

        // Reset then free-run with single-cycle memory.
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("first_req_valid", 32'(bus.imem_req_valid_o), 32'd1);
        check("first_req_addr", bus.imem_addr_o, RESET_PC);
        p0 = pops;
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 1);
        check("freerun_progress", 32'(pops - p0 >= 12), 32'd1);

        // Decode stall for five cycles; fetching must stop once the credit is used up.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        check("stall_blocks_req", 32'(bus.imem_req_valid_o), 32'd0);
        check("stall_if_valid", 32'(bus.if_valid_o), 32'd1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

        // Redirect to 0x100 with two requests in flight.
        dmin = 3; dmax = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0, 1, 1);
            if (mq.size() == 2) found = 1;
        end
        check("two_in_flight", 32'(found), 32'd1);
        step(0, 1, 32'h0000_0100, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);

        // Redirect to 0x103 in the same cycle as a response.
        dmin = 1; dmax = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                step(0, 1, 32'h0000_0103, 1, 1);
                found = 1;
                check("redir_rsp_coincide", 32'(bus.imem_rsp_valid_i), 32'd1);
            end else begin
                step(0, 0, 0, 1, 1);
            end
        end
        check("redir_with_rsp_seen", 32'(found), 32'd1);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);

        // PC wrap past 0xFFFFFFFC.
        step(0, 1, 32'hFFFF_FFF9, 1, 1);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);

        // Reset while the buffer is full.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 0, 0, 0, 1);
            if (!bus.imem_req_valid_o && bus.if_valid_o) found = 1;
        end
        check("buffer_full_reached", 32'(found), 32'd1);
        step(1, 0, 0, 0, 1);
        check("midrst_if_valid", 32'(bus.if_valid_o), 32'd0);
        check("midrst_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
        step(0, 0, 0, 1, 1);
        check("post_rst_if_valid", 32'(bus.if_valid_o), 32'd0);
        check("post_rst_req_addr", bus.imem_addr_o, RESET_PC);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

        // Random traffic: variable latency, back-pressure, redirects and resets.
        dmin = 1; dmax = 4;
        for (int i = 0; i < 1500; i++) begin
            bit r, rd;
            r  = ($urandom_range(0, 199) == 0);
            rd = !r && ($urandom_range(0, 29) == 0);
            step(r, rd, ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
